i2c_slave: RTL and testbench
============================

Name: i2c_slave

Overview:
- I2C target (responder) that is the far end of the I2C_M master used by the UART bridge.
- Samples open-drain SCL/SDA and detects START, repeated START and STOP.
- Matches a 7-bit address, ACKs, delivers written bytes to a user port, and serves read bytes from a user port.
- Used as an on-chip loopback target for bridge bring-up and as a reusable peripheral front end. No clock stretching; SCL is input only.

Parameters:
- ADDR, 7'h50, 7-bit target address compared against the first byte after START.
- FILTER_LEN, 3, consecutive equal samples needed before a filtered line changes.

Ports:
- clock  input  1  system clock; all logic on posedge.
- reset  input  1  synchronous, active-high reset.
- SCL_i  input  1  SCL as read from the pad buffer.
- SDA_i  input  1  SDA as read from the pad buffer.
- SDA_t  output 1  tristate control; 1 = released (high-Z), 0 = drive SDA_o.
- SDA_o  output 1  drive value; constant 0 (open-drain).
- ackEn  input  1  1 = ACK received data bytes; 0 = NACK them. Address ACK is unaffected.
- dataW  input  8  byte to transmit on master read.
- txReq  output 1  one-cycle pulse: next read byte needed.
- dataR  output 8  last received data byte.
- rxValid output 1  one-cycle pulse: dataR updated.
- RW     output 1  R/W bit of the last matched address (1 = read).
- busy   output 1  high from address match until STOP, START, or reset.
- startDet output 1  one-cycle pulse on START or repeated START.
- stopDet  output 1  one-cycle pulse on STOP.
- nackRx   output 1  one-cycle pulse when the master NACKs a read byte.
- state    output 4  FSM state encoding, for debug.

Behaviour:
- Reset values:
  - SDA_t=1, SDA_o=0, dataR=0, RW=0.
  - rxValid, txReq, startDet, stopDet, nackRx, busy = 0.
  - state=IDLE; filters preset to 1.
- Reset mid-transfer releases SDA on the cycle after reset is sampled.
- Line conditioning:
  - Each line passes through a 2-flop synchronizer, then the glitch filter.
  - Input-to-filtered latency is 2+FILTER_LEN clocks.
  - SCL high and low times must each be at least FILTER_LEN+4 clocks.
- Edges and bus conditions are taken from the filtered lines:
  - START: SDA falls while SCL is high.
  - STOP: SDA rises while SCL is high.
- Data is sampled on the SCL rising edge.
- SDA_t changes only on the clock after an SCL falling edge is detected.
- States, with 0-based encodings in the order listed:
  - IDLE: wait for START.
  - ADDR: shift 8 bits MSB-first. On the 8th rise, if bits[7:1]==ADDR, latch RW and set busy; otherwise go to IGNORE.
  - ADDR_ACK: drive SDA low for one SCL period (falling edge to falling edge), then release.
    - RW=0: go to WR_DATA.
    - RW=1: pulse txReq, latch dataW exactly 2 clocks later, go to RD_DATA.
  - WR_DATA: shift 8 bits. After the 8th rise, dataR<=byte and rxValid pulses the same cycle. Go to WR_ACK.
  - WR_ACK: if ackEn (sampled at the 8th rise), drive low for one SCL period; else stay released. Return to WR_DATA.
  - RD_DATA: present the latched byte MSB-first. The first bit is driven after the ADDR_ACK/RD_ACK falling edge; each subsequent bit after each fall. SDA_t = bit (1 releases). After the 8th falling edge, release SDA and go to RD_ACK.
  - RD_ACK: sample master ACK on SCL rise.
    - ACK (0): pulse txReq, latch dataW 2 clocks later, go to RD_DATA.
    - NACK (1): pulse nackRx, go to IGNORE.
  - IGNORE: SDA released; wait for START or STOP.
- START from any state (including mid-byte or during ACK):
  - Pulse startDet, release SDA, clear the bit counter and busy, go to ADDR.
  - A partial byte is discarded with no rxValid.
- STOP from any state: pulse stopDet, release SDA, clear busy, go to IDLE.
- If START and an SCL edge are detected on the same cycle, START wins.
- Bit counter is 3 bits and wraps 7→0 at byte end.
- dataR holds its value until the next complete write byte.
- General call and 10-bit addressing are unsupported; such addresses are treated as mismatches.

Decomposition:
- Shared package i2c_pkg:
  - State localparams IDLE..IGNORE.
  - ACK=0, NACK=1.
  - Default address constant.
  - Shared with I2C_M benches.
- Sub-module i2c_line_filter (synchronizer + FILTER_LEN glitch filter + rise/fall pulses), instantiated for SCL and SDA.

Test Plan:
- Write transaction:
  - Stimulus: master START, 0xA0 (0x50 W), 0xA5, 0x3C, STOP with ackEn=1.
  - Response: ACK on all 3 bytes; rxValid twice with dataR=0xA5 then 0x3C; RW=0; busy high until stopDet.
- Address mismatch:
  - Stimulus: START, 0xA2 (0x51 W), 0x11, STOP.
  - Response: SDA_t stays 1 throughout; no rxValid; busy stays 0; state reaches IGNORE, then IDLE.
- Read transaction:
  - Stimulus: START, 0xA1 (0x50 R); dataW=0x96 on the first txReq and 0x0F on the second; master ACK then NACK.
  - Response: SDA shows 10010110 then 00001111; txReq pulses twice; nackRx pulses once; SDA released before STOP.
- Repeated START with data NACK:
  - Stimulus: write 0xA0 with ackEn=0, then 0x55, then repeated START, then 0xA1.
  - Response: data byte NACKed but rxValid still pulses with 0x55; startDet pulses twice; RW=1 after the second address.
- Glitch rejection:
  - Stimulus: 2-clock low pulse on SCL while SCL is idle high.
  - Response: no bit shifted, no state change.
- Reset mid-read:
  - Stimulus: assert reset while driving bit 3 of 0x00.
  - Response: SDA_t=1 next cycle; all outputs at reset values; the next START is decoded normally.

Source files
------------

// File: rtl/i2c_pkg.sv
// Shared I2C definitions: target FSM states, ACK levels and default address.
package i2c_pkg;

   typedef enum logic [3:0] {
      S_IDLE,
      S_ADDR,
      S_ADDR_ACK,
      S_WR_DATA,
      S_WR_ACK,
      S_RD_DATA,
      S_RD_ACK,
      S_IGNORE
   } i2c_state_t;

   localparam logic ACK  = 1'b0;
   localparam logic NACK = 1'b1;

   localparam logic [6:0] I2C_DEFAULT_ADDR = 7'h50;

endpackage

// File: rtl/i2c_line_filter.sv
// Two-flop synchronizer followed by a FILTER_LEN-sample glitch filter with
// registered rise/fall pulses aligned to the filtered line change.
module i2c_line_filter
   import i2c_pkg::*;
#(
   parameter int unsigned FILTER_LEN = 3
) (
   input  logic i_clock,
   input  logic i_reset,
   input  logic i_line,
   output logic o_line,
   output logic o_rise,
   output logic o_fall
);

   localparam int unsigned CW = $clog2(FILTER_LEN + 1);

   logic          r_sync1;
   logic          r_sync2;
   logic          r_filt;
   logic          r_rise;
   logic          r_fall;
   logic [CW-1:0] r_cnt;

   // r_cnt counts consecutive synchronized samples that disagree with r_filt.
   always_ff @(posedge i_clock) begin
      if (i_reset) begin
         r_sync1 <= 1'b1;
         r_sync2 <= 1'b1;
         r_filt  <= 1'b1;
         r_rise  <= 1'b0;
         r_fall  <= 1'b0;
         r_cnt   <= '0;
      end else begin
         r_sync1 <= i_line;
         r_sync2 <= r_sync1;
         r_rise  <= 1'b0;
         r_fall  <= 1'b0;
         if (r_sync2 == r_filt) begin
            r_cnt <= '0;
         end else if (r_cnt == CW'(FILTER_LEN - 1)) begin
            r_cnt  <= '0;
            r_filt <= r_sync2;
            r_rise <= r_sync2;
            r_fall <= ~r_sync2;
         end else begin
            r_cnt <= r_cnt + CW'(1);
         end
      end
   end

   assign o_line = r_filt;
   assign o_rise = r_rise;
   assign o_fall = r_fall;

endmodule

// File: rtl/i2c_slave.sv
// I2C target: 7-bit address match, write bytes to dataR, read bytes from dataW.
// No clock stretching; SDA is open-drain via SDA_t with SDA_o tied low.
module i2c_slave
   import i2c_pkg::*;
#(
   parameter logic [6:0]  ADDR       = I2C_DEFAULT_ADDR,
   parameter int unsigned FILTER_LEN = 3
) (
   input  logic       clock,
   input  logic       reset,
   input  logic       SCL_i,
   input  logic       SDA_i,
   output logic       SDA_t,
   output logic       SDA_o,
   input  logic       ackEn,
   input  logic [7:0] dataW,
   output logic       txReq,
   output logic [7:0] dataR,
   output logic       rxValid,
   output logic       RW,
   output logic       busy,
   output logic       startDet,
   output logic       stopDet,
   output logic       nackRx,
   output logic [3:0] state
);

   logic w_scl, w_scl_rise, w_scl_fall;
   logic w_sda, w_sda_rise, w_sda_fall;
   logic w_start, w_stop;
   logic [7:0] w_byte;

   i2c_line_filter #(.FILTER_LEN(FILTER_LEN)) u_scl_filt (
      .i_clock (clock),
      .i_reset (reset),
      .i_line  (SCL_i),
      .o_line  (w_scl),
      .o_rise  (w_scl_rise),
      .o_fall  (w_scl_fall)
   );

   i2c_line_filter #(.FILTER_LEN(FILTER_LEN)) u_sda_filt (
      .i_clock (clock),
      .i_reset (reset),
      .i_line  (SDA_i),
      .o_line  (w_sda),
      .o_rise  (w_sda_rise),
      .o_fall  (w_sda_fall)
   );

   i2c_state_t r_state;
   logic [2:0] r_bitcnt;
   logic [7:0] r_shift;
   logic [7:0] r_tx_byte;
   logic [1:0] r_tx_dly;
   logic       r_ack_phase;
   logic       r_ack_en;
   logic       r_first;
   logic       r_sda_t;
   logic [7:0] r_data_r;
   logic       r_rw;
   logic       r_busy;
   logic       r_tx_req;
   logic       r_rx_valid;
   logic       r_start;
   logic       r_stop;
   logic       r_nack;

   assign w_start = w_sda_fall & w_scl;
   assign w_stop  = w_sda_rise & w_scl;
   assign w_byte  = {r_shift[6:0], w_sda};

   always_ff @(posedge clock) begin
      if (reset) begin
         r_state     <= S_IDLE;
         r_bitcnt    <= '0;
         r_shift     <= '0;
         r_tx_byte   <= '0;
         r_tx_dly    <= '0;
         r_ack_phase <= 1'b0;
         r_ack_en    <= 1'b0;
         r_first     <= 1'b0;
         r_sda_t     <= 1'b1;
         r_data_r    <= '0;
         r_rw        <= 1'b0;
         r_busy      <= 1'b0;
         r_tx_req    <= 1'b0;
         r_rx_valid  <= 1'b0;
         r_start     <= 1'b0;
         r_stop      <= 1'b0;
         r_nack      <= 1'b0;
      end else begin
         r_tx_req   <= 1'b0;
         r_rx_valid <= 1'b0;
         r_start    <= 1'b0;
         r_stop     <= 1'b0;
         r_nack     <= 1'b0;
         // dataW is captured two clocks after the txReq pulse is raised
         if (r_tx_dly != 2'd0) begin
            r_tx_dly <= r_tx_dly - 2'd1;
            if (r_tx_dly == 2'd1) r_tx_byte <= dataW;
         end
         if (w_start) begin
            r_start  <= 1'b1;
            r_sda_t  <= 1'b1;
            r_bitcnt <= '0;
            r_busy   <= 1'b0;
            r_first  <= 1'b0;
            r_state  <= S_ADDR;
         end else if (w_stop) begin
            r_stop   <= 1'b1;
            r_sda_t  <= 1'b1;
            r_bitcnt <= '0;
            r_busy   <= 1'b0;
            r_state  <= S_IDLE;
         end else begin
            case (r_state)
               S_ADDR: if (w_scl_rise) begin
                  r_shift  <= w_byte;
                  r_bitcnt <= r_bitcnt + 3'd1;
                  if (r_bitcnt == 3'd7) begin
                     if (w_byte[7:1] == ADDR) begin
                        r_rw        <= w_byte[0];
                        r_busy      <= 1'b1;
                        r_ack_phase <= 1'b0;
                        r_state     <= S_ADDR_ACK;
                        if (w_byte[0]) begin
                           r_tx_req <= 1'b1;
                           r_tx_dly <= 2'd2;
                        end
                     end else begin
                        r_state <= S_IGNORE;
                     end
                  end
               end
               S_ADDR_ACK: if (w_scl_fall) begin
                  if (!r_ack_phase) begin
                     r_sda_t     <= ACK;
                     r_ack_phase <= 1'b1;
                  end else if (r_rw) begin
                     r_sda_t  <= r_tx_byte[7];
                     r_shift  <= {r_tx_byte[6:0], 1'b0};
                     r_bitcnt <= '0;
                     r_state  <= S_RD_DATA;
                  end else begin
                     r_sda_t <= 1'b1;
                     r_state <= S_WR_DATA;
                  end
               end
               S_WR_DATA: if (w_scl_rise) begin
                  r_shift  <= w_byte;
                  r_bitcnt <= r_bitcnt + 3'd1;
                  if (r_bitcnt == 3'd7) begin
                     r_data_r    <= w_byte;
                     r_rx_valid  <= 1'b1;
                     r_ack_en    <= ackEn;
                     r_ack_phase <= 1'b0;
                     r_state     <= S_WR_ACK;
                  end
               end
               S_WR_ACK: if (w_scl_fall) begin
                  if (!r_ack_phase) begin
                     r_sda_t     <= r_ack_en ? ACK : NACK;
                     r_ack_phase <= 1'b1;
                  end else begin
                     r_sda_t <= 1'b1;
                     r_state <= S_WR_DATA;
                  end
               end
               // r_first marks the fall that ends RD_ACK, where bit 7 goes out
               S_RD_DATA: if (w_scl_fall) begin
                  if (r_first) begin
                     r_first <= 1'b0;
                     r_sda_t <= r_tx_byte[7];
                     r_shift <= {r_tx_byte[6:0], 1'b0};
                  end else if (r_bitcnt == 3'd7) begin
                     r_sda_t  <= 1'b1;
                     r_bitcnt <= '0;
                     r_state  <= S_RD_ACK;
                  end else begin
                     r_sda_t  <= r_shift[7];
                     r_shift  <= {r_shift[6:0], 1'b0};
                     r_bitcnt <= r_bitcnt + 3'd1;
                  end
               end
               S_RD_ACK: if (w_scl_rise) begin
                  if (w_sda == ACK) begin
                     r_tx_req <= 1'b1;
                     r_tx_dly <= 2'd2;
                     r_first  <= 1'b1;
                     r_state  <= S_RD_DATA;
                  end else begin
                     r_nack  <= 1'b1;
                     r_state <= S_IGNORE;
                  end
               end
               default: ;
            endcase
         end
      end
   end

   assign SDA_t    = r_sda_t;
   assign SDA_o    = 1'b0;
   assign txReq    = r_tx_req;
   assign dataR    = r_data_r;
   assign rxValid  = r_rx_valid;
   assign RW       = r_rw;
   assign busy     = r_busy;
   assign startDet = r_start;
   assign stopDet  = r_stop;
   assign nackRx   = r_nack;
   assign state    = r_state;

endmodule

// File: tb/tb_i2c_slave.sv
// Bench for i2c_slave: bit-banged I2C master with a transaction-level model
// of the expected ACKs, received bytes, read data and event pulses.
module tb_i2c_slave;

   localparam int         T          = 16;       // clocks per SCL half-period
   localparam logic [6:0] MODEL_ADDR = 7'h50;

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic       m_scl = 1'b1;
   logic       m_sda = 1'b1;
   logic       sda_bus;
   logic       ackEn = 1'b1;
   logic [7:0] dataW = 8'h00;
   logic       SDA_t, SDA_o, txReq, rxValid, RW, busy, startDet, stopDet, nackRx;
   logic [7:0] dataR;
   logic [3:0] state;

   int n_chk = 0, n_pass = 0;
   int n_start = 0, n_stop = 0, n_txreq = 0, n_nack = 0, n_drive = 0, n_busy = 0;
   logic [7:0] rx_q[$];
   logic [7:0] tx_q[$];

   always #5 clk = ~clk;

   assign sda_bus = m_sda & (SDA_t | SDA_o);

   i2c_slave #(.ADDR(7'h50), .FILTER_LEN(3)) dut (
      .clock    (clk),
      .reset    (reset),
      .SCL_i    (m_scl),
      .SDA_i    (sda_bus),
      .SDA_t    (SDA_t),
      .SDA_o    (SDA_o),
      .ackEn    (ackEn),
      .dataW    (dataW),
      .txReq    (txReq),
      .dataR    (dataR),
      .rxValid  (rxValid),
      .RW       (RW),
      .busy     (busy),
      .startDet (startDet),
      .stopDet  (stopDet),
      .nackRx   (nackRx),
      .state    (state)
   );

   // Event monitor: records pulses and serves read bytes on txReq
   always @(posedge clk) begin
      #1;
      if (rxValid)  rx_q.push_back(dataR);
      if (txReq) begin
         n_txreq++;
         dataW = (tx_q.size() > 0) ? tx_q.pop_front() : 8'hEE;
      end
      if (startDet) n_start++;
      if (stopDet)  n_stop++;
      if (nackRx)   n_nack++;
      if (!SDA_t)   n_drive++;
      if (busy)     n_busy++;
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
   endtask

   task automatic wclk(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic i2c_start();
      wclk(T/2); m_sda = 1'b1;
      wclk(T/2); m_scl = 1'b1;
      wclk(T);   m_sda = 1'b0;
      wclk(T);   m_scl = 1'b0;
   endtask

   task automatic i2c_stop();
      wclk(T/2); m_sda = 1'b0;
      wclk(T/2); m_scl = 1'b1;
      wclk(T);   m_sda = 1'b1;
      wclk(T);
   endtask

   task automatic i2c_bit(input logic b, input bit glitch, output logic got);
      wclk(T/2); m_sda = b;
      wclk(T/2); m_scl = 1'b1;
      wclk(T/2); got = sda_bus;
      if (glitch) begin
         m_scl = 1'b0; wclk(2); m_scl = 1'b1;
      end
      wclk(T/2); m_scl = 1'b0;
   endtask

   task automatic write_byte(input logic [7:0] b, input bit glitch, output logic ack);
      logic g;
      for (int j = 7; j >= 0; j--) i2c_bit(b[j], glitch && (j == 4), g);
      i2c_bit(1'b1, 1'b0, ack);
   endtask

   task automatic read_byte(input logic mack, output logic [7:0] v);
      logic g;
      for (int j = 7; j >= 0; j--) begin
         i2c_bit(1'b1, 1'b0, g);
         v[j] = g;
      end
      i2c_bit(mack, 1'b0, g);
   endtask

   // One transaction: START, address, nb data bytes, optional STOP.
   // Expectations come from the I2C target rules, not from the RTL.
   task automatic txn(input logic [6:0] a, input logic rw, input int nb,
                      input logic [23:0] bytes, input logic [2:0] acken,
                      input bit glitch, input bit do_stop);
      logic       ack;
      logic [7:0] v;
      bit         match;
      int         s_start, s_stop, s_tx, s_nack;
      match   = (a == MODEL_ADDR);
      s_start = n_start; s_stop = n_stop; s_tx = n_txreq; s_nack = n_nack;
      if (match && rw)
         for (int i = 0; i < nb; i++) tx_q.push_back(bytes[8*i +: 8]);
      i2c_start();
      write_byte({a, rw}, 1'b0, ack);
      check("addr_ack", ack, match ? 1'b0 : 1'b1);
      check("start_det", n_start - s_start, 1);
      if (match) begin
         check("rw", RW, rw);
         check("busy", busy, 1);
      end else begin
         check("busy_nm", busy, 0);
      end
      for (int i = 0; i < nb; i++) begin
         if (!rw) begin
            ackEn = acken[i];
            write_byte(bytes[8*i +: 8], glitch && (i == 0), ack);
            check("data_ack", ack, (match && acken[i]) ? 1'b0 : 1'b1);
            if (match) begin
               check("rx_cnt", rx_q.size(), 1);
               if (rx_q.size() > 0) begin
                  v = rx_q.pop_front();
                  check("rx_data", v, bytes[8*i +: 8]);
               end
            end
         end else begin
            read_byte((i == nb - 1) ? 1'b1 : 1'b0, v);
            check("rd_data", v, match ? bytes[8*i +: 8] : 8'hFF);
         end
      end
      if (!match) check("no_rx", rx_q.size(), 0);
      if (rw) begin
         check("tx_req", n_txreq - s_tx, match ? nb : 0);
         check("nack_rx", n_nack - s_nack, match ? 1 : 0);
      end
      wclk(T/2);
      check("state_pre", state, (match && !rw) ? 4'd3 : 4'd7);
      check("sda_rel", SDA_t, 1);
      if (do_stop) begin
         i2c_stop();
         check("stop_det", n_stop - s_stop, 1);
         check("state_idle", state, 4'd0);
         check("busy_end", busy, 0);
      end
   endtask

   initial begin
      logic       g, ack;
      int         s0, s1;
      logic [6:0] ra;

      // Reset values
      wclk(4);
      check("rst_sda_t", SDA_t, 1);
      check("rst_sda_o", SDA_o, 0);
      check("rst_dataR", dataR, 0);
      check("rst_rw", RW, 0);
      check("rst_state", state, 0);
      check("rst_pulses", {rxValid, txReq, startDet, stopDet, nackRx, busy}, 0);
      reset = 1'b0;
      wclk(10);

      // Write 0xA5, 0x3C to 0x50
      txn(7'h50, 1'b0, 2, 24'h003CA5, 3'b111, 1'b0, 1'b1);

      // Address mismatch: never drives SDA, never busy
      s0 = n_drive; s1 = n_busy;
      txn(7'h51, 1'b0, 1, 24'h000011, 3'b111, 1'b0, 1'b1);
      check("nm_drive", n_drive - s0, 0);
      check("nm_busy", n_busy - s1, 0);

      // Read 0x96 (ACK) then 0x0F (NACK)
      txn(7'h50, 1'b1, 2, 24'h000F96, 3'b000, 1'b0, 1'b1);

      // Write 0x55 NACKed, then repeated START into a read
      txn(7'h50, 1'b0, 1, 24'h000055, 3'b000, 1'b0, 1'b0);
      txn(7'h50, 1'b1, 1, 24'h0000C9, 3'b000, 1'b0, 1'b1);

      // SCL glitch on the idle bus
      s0 = n_start + n_stop;
      m_scl = 1'b0; wclk(2); m_scl = 1'b1;
      wclk(20);
      check("glitch_state", state, 4'd0);
      check("glitch_evt", n_start + n_stop - s0, 0);

      // SCL glitch during a data bit's high phase must not add a bit
      txn(7'h50, 1'b0, 1, 24'h0000C3, 3'b111, 1'b1, 1'b1);

      // Reset while the target drives bit 3 of a 0x00 read byte
      tx_q.push_back(8'h00);
      i2c_start();
      write_byte(8'hA1, 1'b0, ack);
      check("rst_addr_ack", ack, 0);
      for (int j = 7; j >= 4; j--) begin
         i2c_bit(1'b1, 1'b0, g);
         check("rst_bit", g, 0);
      end
      wclk(T/2);
      check("rst_drive", SDA_t, 0);
      reset = 1'b1;
      wclk(1);
      check("mid_rst_sda_t", SDA_t, 1);
      check("mid_rst_state", state, 0);
      check("mid_rst_rw", RW, 0);
      check("mid_rst_dataR", dataR, 0);
      check("mid_rst_busy", busy, 0);
      reset = 1'b0;
      m_sda = 1'b1;
      wclk(T); m_scl = 1'b1;
      wclk(T);
      txn(7'h50, 1'b0, 1, 24'h000077, 3'b111, 1'b0, 1'b1);

      // Randomized transactions
      for (int k = 0; k < 8; k++) begin
         ra = ($urandom_range(0, 1) == 1) ? 7'h50 : 7'($urandom_range(0, 127));
         txn(ra, 1'($urandom_range(0, 1)), $urandom_range(1, 3), 24'($urandom),
             3'($urandom), 1'b0, 1'b1);
      end

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
